// File: rtl/riscv_div_ctrl.sv
// Front-end controller for a shared serial divider (riscv_alu_div).
// Arbitrates NUM_REQ requesters round-robin, normalises the divisor for the
// selected request, and routes the single result back to its owner. A flush
// abandons the current operation and lets the divider drain silently.
module riscv_div_ctrl #(
    parameter int NUM_REQ     = 2,
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic [NUM_REQ-1:0]           ReqVld_SI,
    output logic [NUM_REQ-1:0]           ReqRdy_SO,
    input  logic [2*NUM_REQ-1:0]         ReqOp_DI,
    input  logic [NUM_REQ*C_WIDTH-1:0]   ReqA_DI,
    input  logic [NUM_REQ*C_WIDTH-1:0]   ReqB_DI,
    output logic [NUM_REQ-1:0]           RspVld_SO,
    input  logic [NUM_REQ-1:0]           RspRdy_SI,
    output logic [C_WIDTH-1:0]           RspData_DO,
    input  logic                         Flush_SI,
    output logic                         Busy_SO,
    output logic [C_WIDTH-1:0]           DivOpA_DO,
    output logic [C_WIDTH-1:0]           DivOpB_DO,
    output logic [C_LOG_WIDTH-1:0]       DivOpBShift_DO,
    output logic                         DivOpBIsZero_SO,
    output logic                         DivOpBSign_SO,
    output logic [1:0]                   DivOpCode_SO,
    output logic                         DivInVld_SO,
    output logic                         DivOutRdy_SO,
    input  logic                         DivOutVld_SI,
    input  logic [C_WIDTH-1:0]           DivRes_DI
);

    localparam int RW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

    state_e          state_d, state_q;
    logic [RW-1:0]   owner_d, owner_q;
    logic [RW-1:0]   rr_d, rr_q;

    logic            grant_vld;
    logic [RW-1:0]   grant_idx;
    int              sel_idx;
    int              own_idx;

    logic [1:0]          sel_op;
    logic [C_WIDTH-1:0]  sel_a;
    logic [C_WIDTH-1:0]  sel_b;
    logic                sel_signed;
    logic                sel_b_zero;

    // Number of positions the divisor can be shifted left without losing
    // magnitude: leading zeros for unsigned, redundant sign bits for signed.
    function automatic logic [C_LOG_WIDTH-1:0] norm_shift(input logic [C_WIDTH-1:0] b,
                                                           input logic is_signed);
        logic ref_bit;
        logic run;
        int   cnt;
        ref_bit = is_signed & b[C_WIDTH-1];
        run     = 1'b1;
        cnt     = 0;
        for (int i = C_WIDTH-1; i >= 0; i--) begin
            if (run && (b[i] == ref_bit)) cnt++;
            else                          run = 1'b0;
        end
        if (is_signed) cnt--;
        return C_LOG_WIDTH'(cnt);
    endfunction

    assign sel_idx = int'(grant_idx);
    assign own_idx = int'(owner_q);

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = rr_q;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (ReqVld_SI[idx]) begin
                grant_vld = 1'b1;
                grant_idx = RW'(idx);
            end
        end
    end

    // Operand preprocessing for the requester currently selected by the arbiter.
    always_comb begin
        sel_op     = ReqOp_DI[2*sel_idx +: 2];
        sel_a      = ReqA_DI[sel_idx*C_WIDTH +: C_WIDTH];
        sel_b      = ReqB_DI[sel_idx*C_WIDTH +: C_WIDTH];
        sel_signed = sel_op[0];
        sel_b_zero = (sel_b == '0);

        DivOpA_DO       = sel_a;
        DivOpCode_SO    = sel_op;
        DivOpBSign_SO   = sel_signed & sel_b[C_WIDTH-1];
        DivOpBIsZero_SO = sel_b_zero;
        if (sel_b_zero) begin
            DivOpBShift_DO = C_LOG_WIDTH'(C_WIDTH-1);
            DivOpB_DO      = '0;
        end else begin
            DivOpBShift_DO = norm_shift(sel_b, sel_signed);
            DivOpB_DO      = sel_b << DivOpBShift_DO;
        end
    end

    // Handshake decode and next-state logic for arbitration, ownership and drain.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        ReqRdy_SO    = '0;
        RspVld_SO    = '0;
        DivInVld_SO  = 1'b0;
        DivOutRdy_SO = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!Flush_SI && grant_vld && DivOutVld_SI) begin
                    ReqRdy_SO[sel_idx] = 1'b1;
                    DivInVld_SO        = 1'b1;
                    owner_d            = grant_idx;
                    rr_d               = (sel_idx == NUM_REQ-1) ? '0 : grant_idx + RW'(1);
                    state_d            = BUSY;
                end
            end
            BUSY: begin
                if (Flush_SI) begin
                    // Discard the result; if it is already there, consume it now.
                    if (DivOutVld_SI) begin
                        DivOutRdy_SO = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d      = DRAIN;
                    end
                end else begin
                    RspVld_SO[own_idx] = DivOutVld_SI;
                    DivOutRdy_SO       = RspRdy_SI[own_idx];
                    if (DivOutVld_SI && RspRdy_SI[own_idx]) state_d = IDLE;
                end
            end
            DRAIN: begin
                DivOutRdy_SO = 1'b1;
                if (DivOutVld_SI) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    assign Busy_SO    = (state_q != IDLE);
    assign RspData_DO = DivRes_DI;

endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Directed bench for riscv_div_ctrl with a cycle-level model of the serial
// divider (IDLE -> DIVIDE for shift+1 cycles -> FINISH).
module tb_riscv_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_vld, req_rdy;
    logic [3:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [1:0]  rsp_vld, rsp_rdy;
    logic [31:0] rsp_data;
    logic        flush, busy;
    logic [31:0] div_opa, div_opb;
    logic [5:0]  div_shift;
    logic        div_zero, div_sign;
    logic [1:0]  div_code;
    logic        div_in_vld, div_out_rdy, div_out_vld;
    logic [31:0] div_res;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_div_ctrl #(.NUM_REQ(2), .C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqVld_SI(req_vld), .ReqRdy_SO(req_rdy), .ReqOp_DI(req_op),
        .ReqA_DI(req_a), .ReqB_DI(req_b),
        .RspVld_SO(rsp_vld), .RspRdy_SI(rsp_rdy), .RspData_DO(rsp_data),
        .Flush_SI(flush), .Busy_SO(busy),
        .DivOpA_DO(div_opa), .DivOpB_DO(div_opb), .DivOpBShift_DO(div_shift),
        .DivOpBIsZero_SO(div_zero), .DivOpBSign_SO(div_sign), .DivOpCode_SO(div_code),
        .DivInVld_SO(div_in_vld), .DivOutRdy_SO(div_out_rdy),
        .DivOutVld_SI(div_out_vld), .DivRes_DI(div_res)
    );

    // ---------------- divider model ----------------
    typedef enum logic [1:0] {M_IDLE, M_DIV, M_FIN} mstate_e;
    mstate_e     m_state;
    logic [5:0]  m_cnt;

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] opb, input logic [5:0] sh,
                                            input logic z);
        logic [31:0]        b;
        logic signed [31:0] sa, sb;
        logic               ovf;
        b   = op[0] ? 32'($signed(opb) >>> sh) : (opb >> sh);
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (z) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'd0:    return a / b;
            2'd1:    return ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'd2:    return a % b;
            default: return ovf ? 32'h0 : 32'(sa % sb);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= M_IDLE;
            m_cnt   <= '0;
            div_res <= '0;
        end else begin
            case (m_state)
                M_IDLE: if (div_in_vld) begin
                    div_res <= ref_res(div_code, div_opa, div_opb, div_shift, div_zero);
                    m_cnt   <= div_shift;
                    m_state <= M_DIV;
                end
                M_DIV: if (m_cnt == 0) m_state <= M_FIN; else m_cnt <= m_cnt - 1'b1;
                default: if (div_out_rdy) m_state <= M_IDLE;
            endcase
        end
    end
    assign div_out_vld = (m_state != M_DIV);

    // ---------------- helpers (no comparisons) ----------------
    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*r +: 2]  = op;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; req_vld = '0; rsp_rdy = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called at posedge+1 of the cycle after issue; lat counts cycles from issue.
    task automatic wait_rsp(input int r, input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            #1;
            if (rsp_vld[r]) begin lat = k; break; end
            @(posedge clk); #1;
        end
    endtask

    // One complete transaction on requester r; captures what was observed.
    task automatic do_op(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [1:0] rdy, output logic [5:0] sh, output logic [31:0] opb,
                         output logic zf, output logic sf, output int lat, output logic [31:0] data);
        set_req(r, op, a, b);
        req_vld[r] = 1'b1;
        #1;
        rdy = req_rdy; sh = div_shift; opb = div_opb; zf = div_zero; sf = div_sign;
        tick;
        req_vld[r] = 1'b0;
        wait_rsp(r, 80, lat);
        data = rsp_data;
        rsp_rdy[r] = 1'b1;
        tick;
        rsp_rdy[r] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; req_vld = '0; rsp_rdy = '0; flush = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        #3;
        checks++; if ({req_rdy, rsp_vld} !== 4'b0) begin errors++; $display("FAIL reset_rdy_vld: got %b want 0000", {req_rdy, rsp_vld}); end
        checks++; if ({div_in_vld, div_out_rdy, busy} !== 3'b0) begin errors++; $display("FAIL reset_div_ctl: got %b want 000", {div_in_vld, div_out_rdy, busy}); end
        apply_reset;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after: got %b want 0", busy); end
        tick;
    endtask

    task automatic test_divu;
        logic [1:0] rdy; logic [5:0] sh; logic [31:0] opb, data; logic zf, sf; int lat;
        do_op(0, 2'd0, 32'd100, 32'd7, rdy, sh, opb, zf, sf, lat, data);
        checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL divu_rdy: got %b want 01", rdy); end
        checks++; if (sh !== 6'd29) begin errors++; $display("FAIL divu_shift: got %0d want 29", sh); end
        checks++; if (opb !== 32'hE000_0000) begin errors++; $display("FAIL divu_opb: got %h want e0000000", opb); end
        checks++; if ({zf, sf} !== 2'b00) begin errors++; $display("FAIL divu_flags: got %b want 00", {zf, sf}); end
        checks++; if (lat !== 31) begin errors++; $display("FAIL divu_latency: got %0d want 31", lat); end
        checks++; if (data !== 32'd14) begin errors++; $display("FAIL divu_data: got %h want 0000000e", data); end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_idle: got busy %b want 0", busy); end
        tick;
    endtask

    task automatic test_signed;
        logic [1:0] rdy; logic [5:0] sh; logic [31:0] opb, data; logic zf, sf; int lat;
        do_op(1, 2'd3, 32'hFFFF_FFF9, 32'd2, rdy, sh, opb, zf, sf, lat, data);
        checks++; if (rdy !== 2'b10) begin errors++; $display("FAIL rem_rdy: got %b want 10", rdy); end
        checks++; if ({sh, opb} !== {6'd29, 32'h4000_0000}) begin errors++; $display("FAIL rem_pre: got %0d/%h want 29/40000000", sh, opb); end
        checks++; if (lat !== 31) begin errors++; $display("FAIL rem_latency: got %0d want 31", lat); end
        checks++; if (data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_data: got %h want ffffffff", data); end
        do_op(1, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, rdy, sh, opb, zf, sf, lat, data);
        checks++; if ({sh, opb, sf} !== {6'd31, 32'h8000_0000, 1'b1}) begin errors++; $display("FAIL removf_pre: got %0d/%h/%b want 31/80000000/1", sh, opb, sf); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL removf_latency: got %0d want 33", lat); end
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL removf_data: got %h want 00000000", data); end
        do_op(1, 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, rdy, sh, opb, zf, sf, lat, data);
        checks++; if (data !== 32'h8000_0000) begin errors++; $display("FAIL divovf_data: got %h want 80000000", data); end
        do_op(1, 2'd3, 32'd100, 32'hFFFF_FFF9, rdy, sh, opb, zf, sf, lat, data);
        checks++; if ({sh, opb, sf} !== {6'd28, 32'h9000_0000, 1'b1}) begin errors++; $display("FAIL remneg_pre: got %0d/%h/%b want 28/90000000/1", sh, opb, sf); end
        checks++; if ({lat == 30, data} !== {1'b1, 32'd2}) begin errors++; $display("FAIL remneg: got lat %0d data %h want 30/00000002", lat, data); end
    endtask

    task automatic test_div_zero;
        logic [1:0] rdy; logic [5:0] sh; logic [31:0] opb, data; logic zf, sf; int lat;
        do_op(0, 2'd1, 32'd5, 32'd0, rdy, sh, opb, zf, sf, lat, data);
        checks++; if ({zf, sf, sh, opb} !== {1'b1, 1'b0, 6'd31, 32'h0}) begin errors++; $display("FAIL dz_pre: got z%b s%b %0d %h want z1 s0 31 00000000", zf, sf, sh, opb); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL dz_latency: got %0d want 33", lat); end
        checks++; if (data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_div_data: got %h want ffffffff", data); end
        do_op(0, 2'd2, 32'd5, 32'd0, rdy, sh, opb, zf, sf, lat, data);
        checks++; if (data !== 32'd5) begin errors++; $display("FAIL dz_remu_data: got %h want 00000005", data); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] grants [4];
        int ng, rsp_n, pulse_err, overlap, gap, first_c;
        logic prev_rdy;
        apply_reset;
        set_req(0, 2'd0, 32'd100, 32'd7);
        set_req(1, 2'd3, 32'hFFFF_FFF9, 32'd2);
        req_vld = 2'b11; rsp_rdy = 2'b11;
        ng = 0; rsp_n = 0; pulse_err = 0; overlap = 0; gap = -1; first_c = 0; prev_rdy = 1'b0;
        for (int c = 0; c < 300 && ng < 4; c++) begin
            #1;
            if (req_rdy != 2'b00) begin
                grants[ng] = req_rdy;
                if (prev_rdy) pulse_err++;
                if (busy) overlap++;
                if (ng == 0) first_c = c;
                if (ng == 1) gap = c - first_c;
                ng++;
            end
            if (rsp_vld != 2'b00) begin
                rsp_n++;
                checks++; if (rsp_data !== (rsp_vld[1] ? 32'hFFFF_FFFF : 32'd14)) begin errors++; $display("FAIL b2b_data: got %h for rsp %b", rsp_data, rsp_vld); end
            end
            prev_rdy = |req_rdy;
            tick;
        end
        req_vld = 2'b00;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (rsp_vld != 2'b00) begin
                rsp_n++;
                checks++; if (rsp_data !== (rsp_vld[1] ? 32'hFFFF_FFFF : 32'd14)) begin errors++; $display("FAIL b2b_data: got %h for rsp %b", rsp_data, rsp_vld); end
            end
            if (!busy) break;
            tick;
        end
        tick;
        rsp_rdy = 2'b00;
        checks++; if (ng !== 4) begin errors++; $display("FAIL b2b_grant_count: got %0d want 4", ng); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (i < ng && grants[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL b2b_grant%0d: got %b", i, grants[i]); end
        end
        checks++; if (gap !== 32) begin errors++; $display("FAIL b2b_period: got %0d want 32", gap); end
        checks++; if ({pulse_err, overlap} !== 64'd0) begin errors++; $display("FAIL b2b_pulse_overlap: got %0d/%0d want 0/0", pulse_err, overlap); end
        checks++; if (rsp_n !== 4) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 4", rsp_n); end
    endtask

    task automatic test_flush;
        int grant_c, rsp_seen, lat;
        logic [1:0] grant_v;
        logic drain_rdy;
        set_req(0, 2'd0, 32'd100, 32'd7);
        req_vld[0] = 1'b1;
        tick;
        req_vld[0] = 1'b0;
        tick; tick;
        flush = 1'b1;
        #1;
        checks++; if ({rsp_vld, busy} !== 3'b001) begin errors++; $display("FAIL flush_cycle: got %b want 001", {rsp_vld, busy}); end
        tick;
        flush = 1'b0;
        set_req(1, 2'd1, 32'hFFFF_FF9C, 32'd7);
        req_vld[1] = 1'b1;
        grant_c = -1; grant_v = '0; rsp_seen = 0; drain_rdy = 1'b0;
        for (int c = 4; c <= 60; c++) begin
            #1;
            if (c == 4) drain_rdy = div_out_rdy;
            if (rsp_vld != 2'b00) rsp_seen++;
            if (req_rdy != 2'b00) begin grant_c = c; grant_v = req_rdy; break; end
            tick;
        end
        checks++; if (drain_rdy !== 1'b1) begin errors++; $display("FAIL flush_drain_outrdy: got %b want 1", drain_rdy); end
        checks++; if (rsp_seen !== 0) begin errors++; $display("FAIL flush_no_rsp: got %0d responses want 0", rsp_seen); end
        checks++; if ({grant_c, grant_v} !== {32'd32, 2'b10}) begin errors++; $display("FAIL flush_regrant: got cycle %0d rdy %b want 32/10", grant_c, grant_v); end
        tick;
        req_vld[1] = 1'b0;
        wait_rsp(1, 60, lat);
        checks++; if ({lat == 30, rsp_data} !== {1'b1, 32'hFFFF_FFF2}) begin errors++; $display("FAIL flush_next_op: got lat %0d data %h want 30/fffffff2", lat, rsp_data); end
        rsp_rdy[1] = 1'b1;
        tick;
        rsp_rdy[1] = 1'b0;
    endtask

    task automatic test_flush_at_done;
        int lat;
        set_req(0, 2'd0, 32'd100, 32'd7);
        req_vld[0] = 1'b1;
        tick;
        req_vld[0] = 1'b0;
        wait_rsp(0, 60, lat);
        checks++; if (lat !== 31) begin errors++; $display("FAIL fdone_latency: got %0d want 31", lat); end
        flush = 1'b1;
        #1;
        checks++; if ({rsp_vld, div_out_rdy} !== 3'b001) begin errors++; $display("FAIL fdone_cycle: got %b want 001", {rsp_vld, div_out_rdy}); end
        tick;
        flush = 1'b0;
        #1;
        checks++; if ({busy, rsp_vld} !== 3'b000) begin errors++; $display("FAIL fdone_idle: got %b want 000", {busy, rsp_vld}); end
        tick;
    endtask

    task automatic test_stall;
        int lat;
        set_req(0, 2'd2, 32'd100, 32'd7);
        req_vld[0] = 1'b1;
        tick;
        req_vld[0] = 1'b0;
        set_req(1, 2'd0, 32'd1, 32'd1);
        req_vld[1] = 1'b1;
        rsp_rdy[1] = 1'b1;
        wait_rsp(0, 60, lat);
        checks++; if (lat !== 31) begin errors++; $display("FAIL stall_latency: got %0d want 31", lat); end
        for (int i = 0; i < 10; i++) begin
            checks++; if ({rsp_vld, req_rdy, div_out_rdy, rsp_data} !== {2'b01, 2'b00, 1'b0, 32'd2}) begin errors++; $display("FAIL stall_hold%0d: got %b/%b/%b/%h want 01/00/0/00000002", i, rsp_vld, req_rdy, div_out_rdy, rsp_data); end
            tick; #1;
        end
        rsp_rdy = 2'b01;
        req_vld[1] = 1'b0;
        tick;
        rsp_rdy = 2'b00;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_release: got busy %b want 0", busy); end
        tick;
    endtask

    task automatic test_reset_mid;
        logic [1:0] rdy; logic [5:0] sh; logic [31:0] opb, data; logic zf, sf; int lat, stray;
        set_req(0, 2'd0, 32'd100, 32'd7);
        req_vld[0] = 1'b1;
        tick;
        req_vld[0] = 1'b0;
        tick; tick;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({req_rdy, rsp_vld, div_in_vld, div_out_rdy, busy} !== 7'b0) begin errors++; $display("FAIL rmid_async: got %b want 0000000", {req_rdy, rsp_vld, div_in_vld, div_out_rdy, busy}); end
        tick;
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rsp_vld != 2'b00 || busy) stray++;
            tick;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d active cycles want 0", stray); end
        do_op(0, 2'd0, 32'd1000, 32'd10, rdy, sh, opb, zf, sf, lat, data);
        checks++; if ({rdy, sh, data} !== {2'b01, 6'd28, 32'd100}) begin errors++; $display("FAIL rmid_recover: got %b/%0d/%h want 01/28/00000064", rdy, sh, data); end
    endtask

    initial begin
        test_reset;
        test_divu;
        test_signed;
        test_div_zero;
        test_back_to_back;
        test_flush;
        test_flush_at_done;
        test_stall;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
